// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared state encodings and register-file constants
package hazard_stall_controller_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;
    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID-stage hazard inputs and pipeline control outputs
interface hazard_stall_controller_if
    import hazard_stall_controller_pkg::*;
    #(parameter int CNT_W = 16);
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_Rt;
    logic [REG_W-1:0] IF_ID_Rs;
    logic [REG_W-1:0] IF_ID_Rt;
    logic             IF_ID_UsesRt;
    logic             BranchTaken;
    logic             Jump;
    logic             BubbleSelect;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    modport slave (
        input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, BranchTaken, Jump,
        output BubbleSelect, PCWrite, IF_ID_Write, IF_ID_Flush, StallCount, FlushCount
    );
    modport master (
        output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, BranchTaken, Jump,
        input  BubbleSelect, PCWrite, IF_ID_Write, IF_ID_Flush, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up on inc until every bit is set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (inc && !(&count)) count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: ID-stage load-use stall and branch/jump flush control
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int FLUSH_CYC  = 1,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic reset,
    hazard_stall_controller_if.slave bus
);
    localparam int MAXC = (LOAD_STALL > FLUSH_CYC) ? LOAD_STALL : FLUSH_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          hazard, ctl, stall, flush, flush_evt;
    assign hazard = bus.ID_EX_MemRead && bus.ID_EX_Rt != ZERO_REG &&
                    (bus.ID_EX_Rt == bus.IF_ID_Rs || (bus.IF_ID_UsesRt && bus.ID_EX_Rt == bus.IF_ID_Rt));
    assign ctl = bus.BranchTaken | bus.Jump;
    // state and remaining-cycle register; reset aborts any stall or flush in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // IDLE decodes the inputs directly so the first bubble/flush has no latency; stalls win over flushes
    always_comb begin
        state_nx  = IDLE;
        cnt_nx    = cnt - CW'(1);
        stall     = 1'b0;
        flush     = 1'b0;
        flush_evt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = cnt;
                if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nx = STALL;
                        cnt_nx   = CW'(LOAD_STALL - 2);
                    end
                end else if (ctl) begin
                    flush     = 1'b1;
                    flush_evt = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_nx = FLUSH;
                        cnt_nx   = CW'(FLUSH_CYC - 2);
                    end
                end
            end
            STALL: begin
                stall    = 1'b1;
                state_nx = (cnt == '0) ? IDLE : STALL;
            end
            FLUSH: begin
                flush    = 1'b1;
                state_nx = (cnt == '0) ? IDLE : FLUSH;
            end
            default: cnt_nx = '0;
        endcase
    end
    assign bus.BubbleSelect = !reset || stall;
    assign bus.PCWrite      = reset && !stall;
    assign bus.IF_ID_Write  = reset && !stall;
    assign bus.IF_ID_Flush  = !reset || flush;
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall), .count(bus.StallCount));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(flush_evt), .count(bus.FlushCount));
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: two parameterisations driven in lockstep and checked against a cycle model
module tb_hazard_stall_controller;
    import hazard_stall_controller_pkg::*;
    logic       clk = 1'b0, reset = 1'b0;
    logic       mr = 1'b0, ur = 1'b0, br = 1'b0, jp = 1'b0;
    logic [4:0] ex_rt = '0, rs = '0, rt = '0;
    int n_chk = 0, n_fail = 0;
    int srem[2], frem[2], sc[2], fcn[2];
    int ls[2] = '{1, 3};
    int fc[2] = '{1, 2};
    int mx[2] = '{65535, 15};
    hazard_stall_controller_if #(.CNT_W(16)) ia();
    hazard_stall_controller_if #(.CNT_W(4))  ib();
    assign ia.ID_EX_MemRead = mr;
    assign ia.ID_EX_Rt      = ex_rt;
    assign ia.IF_ID_Rs      = rs;
    assign ia.IF_ID_Rt      = rt;
    assign ia.IF_ID_UsesRt  = ur;
    assign ia.BranchTaken   = br;
    assign ia.Jump          = jp;
    assign ib.ID_EX_MemRead = mr;
    assign ib.ID_EX_Rt      = ex_rt;
    assign ib.IF_ID_Rs      = rs;
    assign ib.IF_ID_Rt      = rt;
    assign ib.IF_ID_UsesRt  = ur;
    assign ib.BranchTaken   = br;
    assign ib.Jump          = jp;
    hazard_stall_controller #(.LOAD_STALL(1), .FLUSH_CYC(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    hazard_stall_controller #(.LOAD_STALL(3), .FLUSH_CYC(2), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
    always #5 clk = ~clk;
    logic [3:0] oa, ob;
    assign oa = {ia.BubbleSelect, ia.PCWrite, ia.IF_ID_Write, ia.IF_ID_Flush};
    assign ob = {ib.BubbleSelect, ib.PCWrite, ib.IF_ID_Write, ib.IF_ID_Flush};
    typedef struct {
        logic       mr;
        logic [4:0] ex_rt, rs, rt;
        logic       ur, br, jp;
        logic [3:0] o;
    } vec_t;
    vec_t tbl[9];
    function automatic logic hz();
        return mr && ex_rt != 5'd0 && (ex_rt == rs || (ur && ex_rt == rt));
    endfunction
    function automatic logic [3:0] exp_out(int d);
        if (!reset) return 4'b1001;
        if (srem[d] > 0) return 4'b1000;
        if (frem[d] > 0) return 4'b0111;
        if (hz()) return 4'b1000;
        if (br || jp) return 4'b0111;
        return 4'b0110;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            srem[d] = 0;
            frem[d] = 0;
            sc[d]   = 0;
            fcn[d]  = 0;
        end
    endtask
    task automatic model_clk();
        for (int d = 0; d < 2; d++) begin
            if (!reset) continue;
            if (srem[d] > 0) begin
                srem[d]--;
                if (sc[d] < mx[d]) sc[d]++;
            end else if (frem[d] > 0) begin
                frem[d]--;
            end else if (hz()) begin
                srem[d] = ls[d] - 1;
                if (sc[d] < mx[d]) sc[d]++;
            end else if (br || jp) begin
                frem[d] = fc[d] - 1;
                if (fcn[d] < mx[d]) fcn[d]++;
            end
        end
    endtask
    task automatic step();
        #1;
        chk("A outputs", int'(oa), int'(exp_out(0)));
        chk("B outputs", int'(ob), int'(exp_out(1)));
        @(posedge clk);
        model_clk();
        @(negedge clk);
        chk("A StallCount", int'(ia.StallCount), sc[0]);
        chk("B StallCount", int'(ib.StallCount), sc[1]);
        chk("A FlushCount", int'(ia.FlushCount), fcn[0]);
        chk("B FlushCount", int'(ib.FlushCount), fcn[1]);
    endtask
    task automatic clr_in();
        mr = 0; ur = 0; br = 0; jp = 0; ex_rt = 0; rs = 0; rt = 0;
    endtask
    task automatic do_reset();
        reset = 0;
        clr_in();
        model_reset();
        step();
        reset = 1;
    endtask
    initial begin
        tbl[0] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1000};
        tbl[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0110};
        tbl[2] = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 4'b0110};
        tbl[3] = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b1000};
        tbl[4] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 4'b0110};
        tbl[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0111};
        tbl[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0111};
        tbl[7] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1000};
        tbl[8] = '{1'b1, 5'd3, 5'd4, 5'd3, 1'b0, 1'b1, 1'b1, 4'b0111};
        model_reset();
        @(negedge clk);
        #1;
        chk("reset outputs", int'(oa), 4'b1001);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {mr, ex_rt, rs, rt, ur, br, jp} = {tbl[i].mr, tbl[i].ex_rt, tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].br, tbl[i].jp};
            #1;
            chk($sformatf("table %0d", i), int'(oa), int'(tbl[i].o));
            step();
        end
        chk("table StallCount", int'(ia.StallCount), 3);
        chk("table FlushCount", int'(ia.FlushCount), 3);
        do_reset();
        mr = 1; ex_rt = 8; rs = 8;
        #1 chk("stall3 c1", int'(ob), 4'b1000);
        step();
        mr = 0; jp = 1;
        #1 chk("stall3 c2", int'(ob), 4'b1000);
        step();
        rs = 3;
        #1 chk("stall3 c3", int'(ob), 4'b1000);
        step();
        chk("stall3 StallCount", int'(ib.StallCount), 3);
        #1 chk("stall3 release", int'(ob), 4'b0111);
        step();
        clr_in();
        do_reset();
        mr = 1; ex_rt = 5; rs = 5; br = 1;
        #1 chk("prio stall", int'(oa), 4'b1000);
        step();
        chk("prio FlushCount", int'(ia.FlushCount), 0);
        mr = 0;
        #1 chk("prio flush", int'(oa), 4'b0111);
        step();
        chk("prio FlushCount after", int'(ia.FlushCount), 1);
        clr_in();
        do_reset();
        jp = 1;
        #1 chk("flush2 c1", int'(ob), 4'b0111);
        step();
        jp = 0;
        #1 chk("flush2 c2", int'(ob), 4'b0111);
        reset = 0;
        model_reset();
        #1 chk("flush2 reset forced", int'(ob), 4'b1001);
        step();
        chk("flush2 FlushCount reset", int'(ib.FlushCount), 0);
        reset = 1;
        #1 chk("flush2 release idle", int'(ob), 4'b0110);
        step();
        do_reset();
        mr = 1; ex_rt = 7; rs = 7;
        repeat (20) step();
        chk("sat StallCount B", int'(ib.StallCount), 15);
        chk("sat StallCount A", int'(ia.StallCount), 20);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mr = 1'($urandom_range(0, 1));
            ur = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 4) == 0);
            jp = ($urandom_range(0, 7) == 0);
            ex_rt = 5'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                reset = 0;
                model_reset();
            end else begin
                reset = 1;
            end
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
